raise: RTL and testbench
========================

Name: raise

Overview:
- Shift-control sequencer for the NABP filter-mapper / line-buffer pipeline.
- Takes fill and shift kicks from state control.
- Generates shift enables for the mapper and the line buffer, the PE kick, and fill/shift-done handshakes.
- During shift, a fixed-point accumulator decides per cycle whether the mapper advances: a shift occurs when the running sum crosses an integer pixel boundary.

Parameters:
- IMAGE_SIZE, 8, image side in pixels; shift count initial value = IMAGE_SIZE-2.
- FILL_CNT_INIT, 3, position of the last PE tap; fill count initial value. Legal range 0..IMAGE_SIZE-1; anything outside is an elaboration error.
- ACCU_WIDTH, 8, total accumulator width in bits (unsigned fixed point).
- ACCU_FRAC, 4, fractional bits of the accumulator; integer part = bits [ACCU_WIDTH-1:ACCU_FRAC].

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- sc_fill_kick  in  1  start fill (pulse).
- sc_shift_kick  in  1  start shift (pulse).
- sc_accu_base  in  ACCU_WIDTH  per-pixel accumulator step; stable from fill kick to shift done.
- sc_fill_done  out  1  fill complete pulse.
- sc_shift_done  out  1  shift complete pulse.
- mp_kick  out  1  mapper kick.
- mp_done  out  1  mapper done.
- mp_shift_en  out  1  mapper shift enable.
- lb_clear  out  1  line-buffer clear.
- lb_shift_en  out  1  line-buffer shift enable.
- sw_pe_kick  out  1  PE kick.

Behaviour:

Reset:
- Asynchronous reset forces state=READY and cnt=FILL_CNT_INIT.
- Reset also clears accu, every delay register and the registered shift kick.
- Outputs during and after reset: sc_fill_done=0, sc_shift_done=0, lb_shift_en=0, mp_shift_en=0, sw_pe_kick=0, mp_done=0.

Counter width:
- Down-counter cnt, width = max(clog2(IMAGE_SIZE-1), clog2(FILL_CNT_INIT+1), 1).

State machine (READY, FILL, FILL_DONE, SHIFT):
- READY:
  - Every cycle: cnt<=FILL_CNT_INIT and accu<=sc_accu_base>>1 (half-step offset so shifts happen at pixel boundaries).
  - sc_fill_kick -> FILL.
- FILL:
  - cnt decrements while nonzero.
  - fill_done_l = (cnt==0) in FILL; on it -> FILL_DONE.
  - FILL lasts FILL_CNT_INIT+1 cycles.
- FILL_DONE:
  - cnt<=IMAGE_SIZE-2; accu holds.
  - Moves to SHIFT when sc_shift_kick_d is high (sc_shift_kick registered 1 cycle).
- SHIFT:
  - While cnt!=0: cnt<=cnt-1 and accu<=accu_next.
  - shift_done_l = (cnt==0) in SHIFT; on it -> READY.
  - SHIFT lasts IMAGE_SIZE-1 cycles.

Arithmetic:
- accu_next = accu + sc_accu_base, modulo 2^ACCU_WIDTH; wrap is allowed.

Outputs:
- mp_shift_en (combinational) = (state==FILL) OR (state==SHIFT AND int(accu_next) != int(accu)). In the final SHIFT cycle the compare is still evaluated even though accu does not update.
- lb_shift_en = mp_shift_en delayed 1 cycle.
- sc_fill_done = fill_done_l delayed 2 cycles.
- sc_shift_done = shift_done_l delayed 2 cycles.
- mp_done = sc_shift_done.
- sw_pe_kick = sc_shift_kick_d.
- mp_kick = lb_clear = sc_fill_kick (combinational pass-through, in any state).

Boundary conditions:
- sc_fill_kick outside READY is ignored by the FSM but is still passed through on mp_kick and lb_clear.
- A shift kick whose registered copy does not fall within FILL_DONE is lost; FILL_DONE waits indefinitely for the next one.
- FILL_CNT_INIT=0: FILL lasts exactly 1 cycle.
- Reset mid-operation aborts immediately to READY and clears all delay-pipe contents (no done pulses emerge afterwards).

Decomposition:
- Package raise_pkg holds:
  - State enum (READY, FILL, FILL_DONE, SHIFT).
  - Derived constants: SHIFT_CNT_INIT=IMAGE_SIZE-2 and CNT_WIDTH.
  - Elaboration check FILL_CNT_INIT<=IMAGE_SIZE-1.
- One sub-module raise_delay (parameterised depth, async-reset shift register) used for the 1-cycle and 2-cycle delays.

Test Plan (IMAGE_SIZE=8, FILL_CNT_INIT=3, ACCU_WIDTH=8, ACCU_FRAC=4):
- Reset: assert reset_n=0 mid-SHIFT -> state READY immediately; all outputs except the pass-throughs are 0; no late done pulses.
- Fill: pulse sc_fill_kick in READY ->
  - mp_kick and lb_clear high the same cycle;
  - mp_shift_en high 4 cycles; lb_shift_en the same 4 cycles shifted by 1;
  - sc_fill_done a 1-cycle pulse 2 cycles after the last FILL cycle.
- Shift, sc_accu_base=0x10 (1.0): kick shift in FILL_DONE ->
  - sw_pe_kick 1 cycle after the kick;
  - SHIFT lasts 7 cycles with mp_shift_en=1 every cycle;
  - sc_shift_done and mp_done pulse 2 cycles after the last SHIFT cycle.
- Shift, sc_accu_base=0x08 (0.5): accu starts at 0x04 -> mp_shift_en pattern 0,1,0,1,0,1,0 over 7 cycles; final accu=0x34.
- Ignored kicks:
  - sc_fill_kick during SHIFT -> no state change, but lb_clear and mp_kick still pulse.
  - sc_shift_kick in READY -> stays READY.
- Wrap: sc_accu_base=0xF0 -> accumulator wraps without error; mp_shift_en=1 whenever the integer field changes.

Source files
------------

// File: rtl/raise_pkg.sv
// Shared types, default configuration and derived-constant helpers for the
// raise shift-control sequencer.
package raise_pkg;

    // Default configuration of the NABP filter-mapper / line-buffer pipeline.
    localparam int IMAGE_SIZE_DEF    = 8;
    localparam int FILL_CNT_INIT_DEF = 3;
    localparam int ACCU_WIDTH_DEF    = 8;
    localparam int ACCU_FRAC_DEF     = 4;

    // Sequencer phases.
    typedef enum logic [1:0] {
        READY     = 2'd0,
        FILL      = 2'd1,
        FILL_DONE = 2'd2,
        SHIFT     = 2'd3
    } state_e;

    // Shift phase counts down from here; it lasts image_size-1 cycles.
    function automatic int shift_cnt_init(input int image_size);
        return image_size - 2;
    endfunction

    // Down-counter must hold both the fill and the shift start values.
    function automatic int cnt_width(input int image_size, input int fill_init);
        int w;
        w = 1;
        if ($clog2(image_size - 1) > w) w = $clog2(image_size - 1);
        if ($clog2(fill_init + 1) > w)  w = $clog2(fill_init + 1);
        return w;
    endfunction

    // Legal configuration: last PE tap inside the image, integer field present.
    function automatic bit config_ok(input int image_size, input int fill_init,
                                     input int accu_width, input int accu_frac);
        return (image_size >= 2) && (fill_init >= 0) &&
               (fill_init <= image_size - 1) &&
               (accu_frac >= 0) && (accu_frac < accu_width);
    endfunction

    localparam int SHIFT_CNT_INIT = shift_cnt_init(IMAGE_SIZE_DEF);
    localparam int CNT_WIDTH      = cnt_width(IMAGE_SIZE_DEF, FILL_CNT_INIT_DEF);

endpackage

// File: rtl/raise_if.sv
// Handshake bundle between state control, the sequencer, the mapper,
// the line buffer and the PE array.
interface raise_if
    import raise_pkg::*;
#(
    parameter int ACCU_WIDTH = ACCU_WIDTH_DEF
);
    logic                  sc_fill_kick;
    logic                  sc_shift_kick;
    logic [ACCU_WIDTH-1:0] sc_accu_base;
    logic                  sc_fill_done;
    logic                  sc_shift_done;
    logic                  mp_kick;
    logic                  mp_done;
    logic                  mp_shift_en;
    logic                  lb_clear;
    logic                  lb_shift_en;
    logic                  sw_pe_kick;

    // State-control side: issues kicks, observes the sequencer outputs.
    modport master (
        output sc_fill_kick, sc_shift_kick, sc_accu_base,
        input  sc_fill_done, sc_shift_done, mp_kick, mp_done,
               mp_shift_en, lb_clear, lb_shift_en, sw_pe_kick
    );

    // Sequencer side.
    modport slave (
        input  sc_fill_kick, sc_shift_kick, sc_accu_base,
        output sc_fill_done, sc_shift_done, mp_kick, mp_done,
               mp_shift_en, lb_clear, lb_shift_en, sw_pe_kick
    );
endinterface

// File: rtl/raise_delay.sv
// Fixed-depth delay line with asynchronous clear, used to retime kicks,
// shift enables and done strobes.
module raise_delay #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

    // Shift the pipe by one stage per clock; reset empties every stage.
    // NOTE: every stage is reset, not just the output, so an aborted
    // operation can never leak a stale done pulse after reset releases.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/raise.sv
// Shift-control sequencer: runs the fill phase, then a shift phase in which
// a fixed-point accumulator advances the mapper whenever the running sum
// crosses an integer pixel boundary.
module raise
    import raise_pkg::*;
#(
    parameter int IMAGE_SIZE    = IMAGE_SIZE_DEF,
    parameter int FILL_CNT_INIT = FILL_CNT_INIT_DEF,
    parameter int ACCU_WIDTH    = ACCU_WIDTH_DEF,
    parameter int ACCU_FRAC     = ACCU_FRAC_DEF
) (
    input  logic     clk,
    input  logic     reset_n,
    raise_if.slave   bus
);
    localparam int CNT_W = cnt_width(IMAGE_SIZE, FILL_CNT_INIT);
    localparam logic [CNT_W-1:0] FILL_INIT  = CNT_W'(FILL_CNT_INIT);
    localparam logic [CNT_W-1:0] SHIFT_INIT = CNT_W'(shift_cnt_init(IMAGE_SIZE));

    generate
        if (!config_ok(IMAGE_SIZE, FILL_CNT_INIT, ACCU_WIDTH, ACCU_FRAC)) begin : g_bad_cfg
            $error("raise: FILL_CNT_INIT must lie in 0..IMAGE_SIZE-1 and ACCU_FRAC < ACCU_WIDTH");
        end
    endgenerate

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [ACCU_WIDTH-1:0] accu_q;
    logic [ACCU_WIDTH-1:0] accu_next;
    logic                  cnt_zero;
    logic                  int_change;
    logic                  shift_kick_q;
    logic                  fill_done_l;
    logic                  shift_done_l;
    logic                  shift_en;
    logic                  fill_done_q;
    logic                  shift_done_q;
    logic                  lb_shift_en_q;

    // Accumulator step and pixel-boundary detection (wraps modulo 2^ACCU_WIDTH).
    // NOTE: every signal written here gets a value on every path, so no
    // latch can be inferred.
    always_comb begin
        accu_next  = accu_q + bus.sc_accu_base;
        int_change = accu_next[ACCU_WIDTH-1:ACCU_FRAC] != accu_q[ACCU_WIDTH-1:ACCU_FRAC];
    end

    assign cnt_zero     = (cnt_q == '0);
    assign fill_done_l  = (state_q == FILL)  && cnt_zero;
    assign shift_done_l = (state_q == SHIFT) && cnt_zero;
    // The boundary compare is still made in the last SHIFT cycle.
    assign shift_en     = (state_q == FILL) || ((state_q == SHIFT) && int_change);

    // Phase sequencing with the shared down-counter and accumulator.
    // NOTE: non-blocking assignments keep all state updates on the same edge,
    // independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= READY;
            cnt_q   <= FILL_INIT;
            accu_q  <= '0;
        end else begin
            unique case (state_q)
                READY: begin
                    cnt_q  <= FILL_INIT;
                    // Half-step offset so shifts land on pixel boundaries.
                    accu_q <= bus.sc_accu_base >> 1;
                    if (bus.sc_fill_kick) state_q <= FILL;
                end
                FILL: begin
                    if (cnt_zero) state_q <= FILL_DONE;
                    else          cnt_q   <= cnt_q - CNT_W'(1);
                end
                FILL_DONE: begin
                    cnt_q <= SHIFT_INIT;
                    if (shift_kick_q) state_q <= SHIFT;
                end
                SHIFT: begin
                    if (cnt_zero) begin
                        state_q <= READY;
                    end else begin
                        cnt_q  <= cnt_q - CNT_W'(1);
                        accu_q <= accu_next;
                    end
                end
                default: state_q <= READY;
            endcase
        end
    end

    raise_delay #(.DEPTH(1)) u_kick_dly (
        .clk(clk), .reset_n(reset_n), .d_i(bus.sc_shift_kick), .q_o(shift_kick_q)
    );

    raise_delay #(.DEPTH(1)) u_en_dly (
        .clk(clk), .reset_n(reset_n), .d_i(shift_en), .q_o(lb_shift_en_q)
    );

    raise_delay #(.DEPTH(2)) u_fill_dly (
        .clk(clk), .reset_n(reset_n), .d_i(fill_done_l), .q_o(fill_done_q)
    );

    raise_delay #(.DEPTH(2)) u_shift_dly (
        .clk(clk), .reset_n(reset_n), .d_i(shift_done_l), .q_o(shift_done_q)
    );

    assign bus.mp_shift_en   = shift_en;
    assign bus.lb_shift_en   = lb_shift_en_q;
    assign bus.sc_fill_done  = fill_done_q;
    assign bus.sc_shift_done = shift_done_q;
    assign bus.mp_done       = shift_done_q;
    assign bus.sw_pe_kick    = shift_kick_q;
    // Fill kick reaches mapper and line buffer in any state.
    assign bus.mp_kick       = bus.sc_fill_kick;
    assign bus.lb_clear      = bus.sc_fill_kick;
endmodule

// File: tb/tb_raise.sv
// Self-checking bench for the raise sequencer: a directed vector table,
// hand-written multi-cycle sequences, and a randomized run against a
// timeline model built from the phase durations and accumulator arithmetic.
module tb_raise;
    import raise_pkg::*;

    localparam int IS   = 8;
    localparam int F    = 3;
    localparam int AW   = 8;
    localparam int AF   = 4;
    localparam int NCYC = 300;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    raise_if #(.ACCU_WIDTH(AW)) bus ();

    raise #(
        .IMAGE_SIZE(IS), .FILL_CNT_INIT(F), .ACCU_WIDTH(AW), .ACCU_FRAC(AF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // {fill_done, shift_done, mp_kick, mp_done, mp_shift_en, lb_clear, lb_shift_en, sw_pe_kick}
    function automatic logic [7:0] outs();
        return {bus.sc_fill_done, bus.sc_shift_done, bus.mp_kick, bus.mp_done,
                bus.mp_shift_en, bus.lb_clear, bus.lb_shift_en, bus.sw_pe_kick};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       fk;
        logic       sk;
        logic [7:0] base;
        logic [7:0] exp;
    } vec_t;

    // Fill, then shift with a given step; checks latencies and enable counts.
    task automatic run_txn(input logic [7:0] b, input int exp_en, input string tag);
        int fill_lat = -1, pe_lat = -1, done_lat = -1;
        int n_en = 0, n_fill_en = 0, n_lb = 0;
        bit md_ok = 1'b1;
        next_cycle();
        bus.sc_accu_base = b;
        bus.sc_fill_kick = 1'b1;
        @(negedge clk);
        check({tag, "_kick_pass"}, 32'({bus.mp_kick, bus.lb_clear}), 32'(2'b11));
        for (int i = 1; i <= 20; i++) begin
            next_cycle();
            bus.sc_fill_kick = 1'b0;
            @(negedge clk);
            n_fill_en += int'(bus.mp_shift_en);
            n_lb      += int'(bus.lb_shift_en);
            if (bus.sc_fill_done && fill_lat < 0) fill_lat = i;
        end
        check({tag, "_fill_en_cycles"}, 32'(n_fill_en), 32'(F + 1));
        check({tag, "_lb_en_cycles"}, 32'(n_lb), 32'(F + 1));
        check({tag, "_fill_done_lat"}, 32'(fill_lat), 32'(F + 3));
        next_cycle();
        bus.sc_shift_kick = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 20; i++) begin
            next_cycle();
            bus.sc_shift_kick = 1'b0;
            @(negedge clk);
            if (bus.sw_pe_kick && pe_lat < 0) pe_lat = i;
            n_en += int'(bus.mp_shift_en);
            if (bus.sc_shift_done && done_lat < 0) done_lat = i;
            if (bus.mp_done !== bus.sc_shift_done) md_ok = 1'b0;
        end
        check({tag, "_pe_kick_lat"}, 32'(pe_lat), 32'd1);
        check({tag, "_shift_en_count"}, 32'(n_en), 32'(exp_en));
        check({tag, "_shift_done_lat"}, 32'(done_lat), 32'(IS + 2));
        check({tag, "_mp_done_eq"}, 32'(md_ok), 32'd1);
    endtask

    // Reset asserted 'at' cycles after the shift kick (step 1.0 per cycle).
    task automatic reset_mid(input int at, input string tag);
        int dones = 0;
        next_cycle();
        bus.sc_accu_base = 8'h10;
        bus.sc_fill_kick = 1'b1;
        next_cycle();
        bus.sc_fill_kick = 1'b0;
        repeat (8) next_cycle();
        bus.sc_shift_kick = 1'b1;
        for (int i = 1; i <= at; i++) begin
            next_cycle();
            bus.sc_shift_kick = 1'b0;
        end
        @(negedge clk);
        check({tag, "_busy_before"}, 32'(bus.mp_shift_en | bus.lb_shift_en), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check({tag, "_outs_in_reset"}, 32'(outs()), 32'd0);
        check({tag, "_state_ready"}, 32'(dut.state_q), 32'(READY));
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            dones += int'(bus.sc_fill_done | bus.sc_shift_done | bus.mp_done);
            next_cycle();
        end
        check({tag, "_no_late_done"}, 32'(dones), 32'd0);
    endtask

    // Randomized stimulus and expected-output timeline.
    logic       fk_a   [NCYC+16];
    logic       sk_a   [NCYC+16];
    logic [7:0] base_a [NCYC+16];
    logic       en_a   [NCYC+16];
    logic       fdl_a  [NCYC+16];
    logic       sdl_a  [NCYC+16];

    task automatic build_random();
        int ready_from = 0, wait_from = 0;
        bit waiting = 1'b0, idle;
        logic [7:0] cur = 8'h10, acc = 8'h0, nxt;
        for (int c = 0; c < NCYC + 16; c++) begin
            fk_a[c] = 1'b0; sk_a[c] = 1'b0; base_a[c] = 8'h0;
            en_a[c] = 1'b0; fdl_a[c] = 1'b0; sdl_a[c] = 1'b0;
        end
        for (int c = 0; c < NCYC; c++) begin
            idle = (c >= ready_from) && !waiting;
            if (idle && $urandom_range(0, 3) == 0) cur = 8'($urandom);
            base_a[c] = cur;
            fk_a[c]   = ($urandom_range(0, 5) == 0);
            sk_a[c]   = ($urandom_range(0, 3) == 0);
            // Shift starts the cycle after a registered kick is seen while waiting.
            if (waiting && c > 0 && c >= wait_from && sk_a[c-1]) begin
                for (int k = 0; k <= IS - 2; k++) begin
                    nxt = acc + cur;
                    en_a[c+1+k] = ((acc >> AF) != (nxt >> AF));
                    if (k < IS - 2) acc = nxt;
                end
                sdl_a[c+IS-1] = 1'b1;
                ready_from = c + IS;
                waiting = 1'b0;
            end
            if (idle && fk_a[c]) begin
                acc = cur >> 1;
                for (int k = 0; k <= F; k++) en_a[c+1+k] = 1'b1;
                fdl_a[c+1+F] = 1'b1;
                wait_from = c + F + 2;
                waiting = 1'b1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [19];
        logic [7:0] e;

        bus.sc_fill_kick  = 1'b0;
        bus.sc_shift_kick = 1'b0;
        bus.sc_accu_base  = 8'h08;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outs", 32'(outs()), 32'd0);
        check("reset_state", 32'(dut.state_q), 32'(READY));
        check("reset_cnt", 32'(dut.cnt_q), 32'(F));
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) next_cycle();

        // Step 0.5: fill, shift, fill kick during SHIFT, shift kick in READY.
        tbl[0]  = '{1'b1, 1'b0, 8'h08, 8'b0010_0100};
        tbl[1]  = '{1'b0, 1'b0, 8'h08, 8'b0000_1000};
        tbl[2]  = '{1'b0, 1'b0, 8'h08, 8'b0000_1010};
        tbl[3]  = '{1'b0, 1'b0, 8'h08, 8'b0000_1010};
        tbl[4]  = '{1'b0, 1'b0, 8'h08, 8'b0000_1010};
        tbl[5]  = '{1'b0, 1'b1, 8'h08, 8'b0000_0010};
        tbl[6]  = '{1'b0, 1'b0, 8'h08, 8'b1000_0001};
        tbl[7]  = '{1'b0, 1'b0, 8'h08, 8'b0000_0000};
        tbl[8]  = '{1'b0, 1'b0, 8'h08, 8'b0000_1000};
        tbl[9]  = '{1'b0, 1'b0, 8'h08, 8'b0000_0010};
        tbl[10] = '{1'b1, 1'b0, 8'h08, 8'b0010_1100};
        tbl[11] = '{1'b0, 1'b0, 8'h08, 8'b0000_0010};
        tbl[12] = '{1'b0, 1'b0, 8'h08, 8'b0000_1000};
        tbl[13] = '{1'b0, 1'b0, 8'h08, 8'b0000_0010};
        tbl[14] = '{1'b0, 1'b0, 8'h08, 8'b0000_0000};
        tbl[15] = '{1'b0, 1'b0, 8'h08, 8'b0101_0000};
        tbl[16] = '{1'b0, 1'b1, 8'h08, 8'b0000_0000};
        tbl[17] = '{1'b0, 1'b0, 8'h08, 8'b0000_0001};
        tbl[18] = '{1'b0, 1'b0, 8'h08, 8'b0000_0000};
        for (int i = 0; i < 19; i++) begin
            next_cycle();
            bus.sc_fill_kick  = tbl[i].fk;
            bus.sc_shift_kick = tbl[i].sk;
            bus.sc_accu_base  = tbl[i].base;
            @(negedge clk);
            check($sformatf("table[%0d]", i), 32'(outs()), 32'(tbl[i].exp));
            if (i == 14) check("table_final_accu", 32'(dut.accu_q), 32'h34);
        end
        next_cycle();
        bus.sc_fill_kick  = 1'b0;
        bus.sc_shift_kick = 1'b0;
        repeat (3) next_cycle();

        run_txn(8'h10, IS - 1, "step_1p0");
        run_txn(8'hF0, IS - 1, "wrap_f0");
        run_txn(8'h04, 1, "step_0p25");

        reset_mid(5, "rst_mid_shift");
        reset_mid(IS + 1, "rst_done_pipe");

        // Randomized run against the timeline model.
        build_random();
        for (int c = 0; c < NCYC; c++) begin
            next_cycle();
            bus.sc_fill_kick  = fk_a[c];
            bus.sc_shift_kick = sk_a[c];
            bus.sc_accu_base  = base_a[c];
            @(negedge clk);
            e = 8'h0;
            if (c >= 2) e[7] = fdl_a[c-2];
            if (c >= 2) e[6] = sdl_a[c-2];
            e[5] = fk_a[c];
            if (c >= 2) e[4] = sdl_a[c-2];
            e[3] = en_a[c];
            e[2] = fk_a[c];
            if (c >= 1) e[1] = en_a[c-1];
            if (c >= 1) e[0] = sk_a[c-1];
            check($sformatf("rand[%0d]", c), 32'(outs()), 32'(e));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
